// File: rtl/gsensor_avg_tare.sv
// Accelerometer conditioning: moving average over 2^LOG2_DEPTH samples, minus a debounced tare offset.
// Optional build macro GSENSOR_SAT_EN clamps the result to [-512, 511] instead of wrapping to 10 bits.
module gsensor_avg_tare #(
  parameter int LOG2_DEPTH   = 3,
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [15:0] iDATA,
  input  logic        iSTB,
  input  logic        iZERO_N,
  output logic [9:0]  oDIG,
  output logic        oVALID,
  output logic        oREADY,
  output logic        oTARED
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SUM_W = 16 + LOG2_DEPTH;
  localparam int DB_W  = $clog2(DEBOUNCE_CYC + 1);

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]              state_q, state_d;
  logic [LOG2_DEPTH-1:0]   wptr_q, wptr_d;
  logic [LOG2_DEPTH-1:0]   fillCnt_q, fillCnt_d;
  logic signed [SUM_W-1:0] sum_q, sum_d;
  logic [15:0]             bufMem_q [DEPTH];
  logic [15:0]             offset_q, offset_d;
  logic                    tared_q, tared_d;
  logic                    stb1_q;
  logic [9:0]              dig_q, dig_d;
  logic                    valid_q, valid_d;
  logic                    ready_q, ready_d;
  logic                    zeroMeta_q, zeroSync_q;
  logic [DB_W-1:0]         dbCnt_q, dbCnt_d;
  logic                    dbFired_q, dbFired_d;

  logic [15:0]             avg16;
  logic [15:0]             oldSample;
  logic signed [16:0]      avg17, off17;
  logic                    tareHit;

  // Arithmetic shift of the running sum is just a slice: the sign bit stays on top.
  assign avg16     = sum_q[LOG2_DEPTH +: 16];
  assign avg17     = {avg16[15], avg16};
  assign off17     = {offset_q[15], offset_q};
  assign oldSample = bufMem_q[wptr_q];
  assign tareHit   = !zeroSync_q && !dbFired_q && (dbCnt_q == DB_W'(DEBOUNCE_CYC - 1));

`ifdef GSENSOR_SAT_EN
  logic signed [16:0] diff;
  assign diff = avg17 - off17;
`endif

  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    fillCnt_d = fillCnt_q;
    sum_d     = sum_q;
    offset_d  = offset_q;
    tared_d   = tared_q;
    dbCnt_d   = dbCnt_q;
    dbFired_d = dbFired_q;

    if (iSTB) begin
      sum_d  = sum_q + {{LOG2_DEPTH{iDATA[15]}}, iDATA} - {{LOG2_DEPTH{oldSample[15]}}, oldSample};
      wptr_d = wptr_q + 1'b1;
      if (state_q == FILL) begin
        if (fillCnt_q == LOG2_DEPTH'(DEPTH - 1)) state_d = RUN;
        else fillCnt_d = fillCnt_q + 1'b1;
      end
    end

    // The fired flag allows one capture per press until the key is released.
    if (zeroSync_q) begin
      dbCnt_d   = '0;
      dbFired_d = 1'b0;
    end else if (tareHit) begin
      dbFired_d = 1'b1;
    end else if (!dbFired_q) begin
      dbCnt_d = dbCnt_q + 1'b1;
    end

    if (tareHit && state_q == RUN) begin
      offset_d = avg16;
      tared_d  = 1'b1;
    end

    valid_d = stb1_q && (state_q == RUN);
    ready_d = ready_q | valid_d;
    dig_d   = dig_q;
    if (valid_d) begin
`ifdef GSENSOR_SAT_EN
      if (diff > 17'sd511)       dig_d = 10'h1FF;
      else if (diff < -17'sd512) dig_d = 10'h200;
      else                       dig_d = diff[9:0];
`else
      dig_d = 10'(avg17 - off17);
`endif
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q    <= FILL;
      wptr_q     <= '0;
      fillCnt_q  <= '0;
      sum_q      <= '0;
      for (int i = 0; i < DEPTH; i++) bufMem_q[i] <= '0;
      offset_q   <= '0;
      tared_q    <= 1'b0;
      stb1_q     <= 1'b0;
      dig_q      <= '0;
      valid_q    <= 1'b0;
      ready_q    <= 1'b0;
      zeroMeta_q <= 1'b0;
      zeroSync_q <= 1'b0;
      dbCnt_q    <= '0;
      dbFired_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      fillCnt_q  <= fillCnt_d;
      sum_q      <= sum_d;
      if (iSTB) bufMem_q[wptr_q] <= iDATA;
      offset_q   <= offset_d;
      tared_q    <= tared_d;
      stb1_q     <= iSTB;
      dig_q      <= dig_d;
      valid_q    <= valid_d;
      ready_q    <= ready_d;
      zeroMeta_q <= iZERO_N;
      zeroSync_q <= zeroMeta_q;
      dbCnt_q    <= dbCnt_d;
      dbFired_q  <= dbFired_d;
    end
  end

  assign oDIG   = dig_q;
  assign oVALID = valid_q;
  assign oREADY = ready_q;
  assign oTARED = tared_q;

endmodule

// File: tb/tb_gsensor_avg_tare.sv
// Directed bench for gsensor_avg_tare: fill, back-to-back averaging, debounced tare, reset behaviour.
// A short debounce time keeps the key tests quick; expectations are hand-computed from the averaging rules.
module tb_gsensor_avg_tare;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic [15:0] iDATA = '0;
  logic        iSTB = 1'b0;
  logic        iZERO_N = 1'b1;
  logic [9:0]  oDIG;
  logic        oVALID, oREADY, oTARED;

  int checkCount = 0;
  int failCount  = 0;
  logic [9:0] digQ [$];

  gsensor_avg_tare #(.LOG2_DEPTH(3), .DEBOUNCE_CYC(20)) dut (
    .iCLK(iCLK), .iRST(iRST), .iDATA(iDATA), .iSTB(iSTB), .iZERO_N(iZERO_N),
    .oDIG(oDIG), .oVALID(oVALID), .oREADY(oREADY), .oTARED(oTARED)
  );

  always #5 iCLK = ~iCLK;

  // Records every displayed result so tests can count strobes and read back the sequence.
  always @(negedge iCLK) begin
    if (oVALID) digQ.push_back(oDIG);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge iCLK);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] v);
    @(posedge iCLK); #1;
    iDATA = v;
    iSTB  = 1'b1;
    @(posedge iCLK); #1;
    iSTB  = 1'b0;
  endtask

  task automatic applyBurst(input logic [15:0] v, input int n);
    @(posedge iCLK); #1;
    iDATA = v;
    iSTB  = 1'b1;
    repeat (n) @(posedge iCLK);
    #1;
    iSTB  = 1'b0;
  endtask

  task automatic pressKey(input int lowCycles);
    iZERO_N = 1'b0;
    waitCycles(lowCycles);
    iZERO_N = 1'b1;
    waitCycles(5);
  endtask

  function automatic logic [31:0] lastDig();
    if (digQ.size() == 0) return 32'hDEAD;
    return {22'b0, digQ[$]};
  endfunction

  initial begin
    int mark;
    logic [9:0] stepExp [8];
    logic [31:0] satExp;
    stepExp = '{10'd75, 10'd50, 10'd25, 10'd0, 10'h3E7, 10'h3CE, 10'h3B5, 10'h39C};
`ifdef GSENSOR_SAT_EN
    satExp = 32'h1FF;
`else
    satExp = 32'h258;
`endif

    waitCycles(3);
    checkOutput("rst_dig", {22'b0, oDIG}, 32'h0);
    checkOutput("rst_valid", {31'b0, oVALID}, 32'h0);
    checkOutput("rst_ready", {31'b0, oREADY}, 32'h0);
    checkOutput("rst_tared", {31'b0, oTARED}, 32'h0);
    iRST = 1'b0;
    waitCycles(4);

    // Fill: seven samples give no strobe, the eighth appears two cycles later.
    mark = digQ.size();
    for (int i = 0; i < 7; i++) applyStimulus(16'd100);
    waitCycles(3);
    checkOutput("fill_novalid", digQ.size() - mark, 32'd0);
    checkOutput("fill_notready", {31'b0, oREADY}, 32'h0);
    applyStimulus(16'd100);
    checkOutput("lat_n1_valid", {31'b0, oVALID}, 32'h0);
    waitCycles(1);
    checkOutput("lat_n2_valid", {31'b0, oVALID}, 32'h1);
    checkOutput("first_dig", {22'b0, oDIG}, 32'd100);
    checkOutput("first_ready", {31'b0, oREADY}, 32'h1);
    waitCycles(2);

    // Back-to-back -100 samples walk the average down in steps of 25.
    mark = digQ.size();
    applyBurst(16'hFF9C, 8);
    waitCycles(4);
    checkOutput("step_count", digQ.size() - mark, 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (mark + i < digQ.size())
        checkOutput($sformatf("step_%0d", i), {22'b0, digQ[mark + i]}, {22'b0, stepExp[i]});
    end

    // Bouncy press at avg 300, then a long hold while the average moves to 500.
    applyBurst(16'd300, 8);
    waitCycles(4);
    for (int b = 0; b < 3; b++) begin
      iZERO_N = 1'b0; waitCycles(5);
      iZERO_N = 1'b1; waitCycles(5);
    end
    checkOutput("bounce_notared", {31'b0, oTARED}, 32'h0);
    iZERO_N = 1'b0;
    waitCycles(30);
    checkOutput("tare_tared", {31'b0, oTARED}, 32'h1);
    applyStimulus(16'd300);
    waitCycles(3);
    checkOutput("tare_zero", lastDig(), 32'd0);
    applyBurst(16'd500, 8);
    waitCycles(30);
    checkOutput("hold_single", lastDig(), 32'd200);
    iZERO_N = 1'b1;
    waitCycles(5);

    // Tare at -200, then 400 gives a difference of 600.
    applyBurst(16'hFF38, 8);
    waitCycles(4);
    checkOutput("avg_neg200", lastDig(), 32'h20C);
    pressKey(30);
    applyBurst(16'd400, 8);
    waitCycles(4);
    checkOutput("sat_or_wrap", lastDig(), satExp);

    // A tare qualified during fill is ignored.
    iRST = 1'b1;
    waitCycles(2);
    iRST = 1'b0;
    checkOutput("rst2_tared", {31'b0, oTARED}, 32'h0);
    pressKey(30);
    checkOutput("fill_tare_ign", {31'b0, oTARED}, 32'h0);
    mark = digQ.size();
    applyBurst(16'd50, 8);
    waitCycles(4);
    checkOutput("fill_tare_cnt", digQ.size() - mark, 32'd1);
    checkOutput("fill_tare_raw", lastDig(), 32'd50);
    checkOutput("fill_tare_still0", {31'b0, oTARED}, 32'h0);

    // Tare at 50, partial refill with 70s (avg 57), then reset mid-window.
    pressKey(30);
    applyBurst(16'd70, 3);
    waitCycles(4);
    checkOutput("pre_rst_dig", lastDig(), 32'd7);
    @(posedge iCLK); #1;
    iDATA = 16'd70;
    iSTB  = 1'b1;
    iRST  = 1'b1;
    @(negedge iCLK);
    checkOutput("midrst_dig", {22'b0, oDIG}, 32'h0);
    checkOutput("midrst_valid", {31'b0, oVALID}, 32'h0);
    checkOutput("midrst_ready", {31'b0, oREADY}, 32'h0);
    checkOutput("midrst_tared", {31'b0, oTARED}, 32'h0);
    waitCycles(2);
    iSTB = 1'b0;
    iRST = 1'b0;
    waitCycles(2);
    mark = digQ.size();
    for (int i = 0; i < 7; i++) applyStimulus(16'd40);
    waitCycles(3);
    checkOutput("refill_novalid", digQ.size() - mark, 32'd0);
    applyStimulus(16'd40);
    waitCycles(3);
    checkOutput("refill_cnt", digQ.size() - mark, 32'd1);
    checkOutput("refill_dig", lastDig(), 32'd40);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
